// File: rtl/waveform_capture_uploader_pkg.sv
// Shared opcodes, header layout constants, FSM states and the sample encoder used by the
// waveform capture/upload path.
package waveform_capture_uploader_pkg;

    localparam logic [7:0]  CMD_WAVE_UPLOAD = 8'hFD;
    localparam logic [7:0]  CMD_WAVE_LOAD   = 8'hFC;
    localparam int unsigned WAVE_HDR_LEN    = 7;
    localparam int unsigned FLAG_CH_BIT     = 3;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StParse,
        StCapture,
        StHdr,
        StDataLo,
        StDataHi
    } upl_state_e;

    // Signed two's complement to offset binary; inverse of the 0xFC load decode.
    function automatic logic [13:0] wave_encode(input logic [13:0] sample);
        return sample ^ 14'h2000;
    endfunction

endpackage

// File: rtl/wave_capture_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read (1-cycle latency).
module wave_capture_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 14,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/waveform_capture_uploader.sv
// Command 0xFD: capture N decimated samples from channel A/B, then stream them upstream as a
// 7-byte header followed by little-endian offset-binary samples.
module waveform_capture_uploader
    import waveform_capture_uploader_pkg::*;
#(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned SAMPLE_W   = 14,
    parameter logic [7:0]  UPLOAD_SRC = 8'hFD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          cmd_type,
    input  logic [7:0]          cmd_data,
    input  logic [15:0]         cmd_data_index,
    input  logic                cmd_start,
    input  logic                cmd_data_valid,
    input  logic                cmd_done,
    output logic                cmd_ready,
    input  logic [SAMPLE_W-1:0] sample_a,
    input  logic [SAMPLE_W-1:0] sample_b,
    input  logic                sample_valid,
    output logic                upload_req,
    output logic [7:0]          upload_source,
    output logic [7:0]          upload_data,
    output logic                upload_valid,
    input  logic                upload_ready,
    output logic                busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    upl_state_e    state_q, state_d;
    logic [7:0]    flags_q, flags_d;
    logic [15:0]   len_q, len_d;
    logic [31:0]   decim_q, decim_d;
    logic [31:0]   dec_cnt_q, dec_cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] smp_cnt_q, smp_cnt_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [2:0]    hdr_idx_q, hdr_idx_d;

    logic                ram_we;
    logic [SAMPLE_W-1:0] ram_wdata, ram_rdata;
    logic [13:0]         enc;
    logic [CW-1:0]       n_calc;
    logic [15:0]         n_ext;
    logic [7:0]          hdr_byte;

    assign ram_wdata = flags_q[FLAG_CH_BIT] ? sample_b : sample_a;
    assign enc       = wave_encode(ram_rdata);
    assign n_calc    = (32'(len_q) > DEPTH) ? CW'(DEPTH) : CW'(len_q);
    assign n_ext     = 16'(n_q);

    // The RAM sees the next read address so the byte for a new state is already on rd_data.
    wave_capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_addr_q),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr_d),
        .rd_data (ram_rdata)
    );

    always_comb begin
        hdr_byte = 8'h00;
        case (hdr_idx_q)
            3'd0:    hdr_byte = flags_q;
            3'd1:    hdr_byte = n_ext[15:8];
            3'd2:    hdr_byte = n_ext[7:0];
            3'd3:    hdr_byte = decim_q[31:24];
            3'd4:    hdr_byte = decim_q[23:16];
            3'd5:    hdr_byte = decim_q[15:8];
            3'd6:    hdr_byte = decim_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        flags_d      = flags_q;
        len_d        = len_q;
        decim_d      = decim_q;
        dec_cnt_d    = dec_cnt_q;
        n_d          = n_q;
        wr_cnt_d     = wr_cnt_q;
        smp_cnt_d    = smp_cnt_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        hdr_idx_d    = hdr_idx_q;
        ram_we       = 1'b0;
        upload_valid = 1'b0;
        upload_data  = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (cmd_start && cmd_type == CMD_WAVE_UPLOAD) begin
                    state_d = StRecv;
                    flags_d = '0;
                    len_d   = '0;
                    decim_d = '0;
                end
            end
            StRecv: begin
                if (cmd_start && cmd_type == CMD_WAVE_UPLOAD) begin
                    flags_d = '0;
                    len_d   = '0;
                    decim_d = '0;
                end else begin
                    if (cmd_data_valid) begin
                        case (cmd_data_index)
                            16'd0:   flags_d          = cmd_data;
                            16'd1:   len_d[15:8]      = cmd_data;
                            16'd2:   len_d[7:0]       = cmd_data;
                            16'd3:   decim_d[31:24]   = cmd_data;
                            16'd4:   decim_d[23:16]   = cmd_data;
                            16'd5:   decim_d[15:8]    = cmd_data;
                            16'd6:   decim_d[7:0]     = cmd_data;
                            default: ;
                        endcase
                    end
                    if (cmd_done) begin
                        state_d = StParse;
                    end
                end
            end
            StParse: begin
                if (len_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    n_d       = n_calc;
                    wr_addr_d = '0;
                    wr_cnt_d  = '0;
                    dec_cnt_d = '0;
                    rd_addr_d = '0;
                    smp_cnt_d = '0;
                    hdr_idx_d = '0;
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (sample_valid) begin
                    if (dec_cnt_q == 32'd0) begin
                        ram_we    = 1'b1;
                        wr_addr_d = wr_addr_q + AW'(1);
                        wr_cnt_d  = wr_cnt_q + CW'(1);
                        dec_cnt_d = decim_q;
                        if (wr_cnt_d == n_q) begin
                            state_d = StHdr;
                        end
                    end else begin
                        dec_cnt_d = dec_cnt_q - 32'd1;
                    end
                end
            end
            StHdr: begin
                upload_valid = 1'b1;
                upload_data  = hdr_byte;
                if (upload_ready) begin
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    if (hdr_idx_q == 3'(WAVE_HDR_LEN - 1)) begin
                        state_d = StDataLo;
                    end
                end
            end
            StDataLo: begin
                upload_valid = 1'b1;
                upload_data  = enc[7:0];
                if (upload_ready) begin
                    state_d = StDataHi;
                end
            end
            StDataHi: begin
                upload_valid = 1'b1;
                upload_data  = {2'b00, enc[13:8]};
                if (upload_ready) begin
                    smp_cnt_d = smp_cnt_q + CW'(1);
                    rd_addr_d = rd_addr_q + AW'(1);
                    state_d   = (smp_cnt_q == n_q - CW'(1)) ? StIdle : StDataLo;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            flags_q   <= '0;
            len_q     <= '0;
            decim_q   <= '0;
            dec_cnt_q <= '0;
            n_q       <= '0;
            wr_cnt_q  <= '0;
            smp_cnt_q <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            hdr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            len_q     <= len_d;
            decim_q   <= decim_d;
            dec_cnt_q <= dec_cnt_d;
            n_q       <= n_d;
            wr_cnt_q  <= wr_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            hdr_idx_q <= hdr_idx_d;
        end
    end

    assign upload_req    = (state_q == StHdr) || (state_q == StDataLo) || (state_q == StDataHi);
    assign upload_source = upload_req ? UPLOAD_SRC : 8'h00;
    assign cmd_ready     = (state_q == StIdle) || (state_q == StRecv);
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_waveform_capture_uploader.sv
// Self-checking bench for waveform_capture_uploader: table-driven cases with random samples
// checked against a byte-stream model, plus hand-written corner sequences.
module tb_waveform_capture_uploader;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cmd_type = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_data_index = '0;
    logic        cmd_start = 1'b0;
    logic        cmd_data_valid = 1'b0;
    logic        cmd_done = 1'b0;
    logic        cmd_ready;
    logic [13:0] sample_a = '0;
    logic [13:0] sample_b = '0;
    logic        sample_valid = 1'b0;
    logic        upload_req;
    logic [7:0]  upload_source;
    logic [7:0]  upload_data;
    logic        upload_valid;
    logic        upload_ready = 1'b0;
    logic        busy;

    waveform_capture_uploader dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_type       (cmd_type),
        .cmd_data       (cmd_data),
        .cmd_data_index (cmd_data_index),
        .cmd_start      (cmd_start),
        .cmd_data_valid (cmd_data_valid),
        .cmd_done       (cmd_done),
        .cmd_ready      (cmd_ready),
        .sample_a       (sample_a),
        .sample_b       (sample_b),
        .sample_valid   (sample_valid),
        .upload_req     (upload_req),
        .upload_source  (upload_source),
        .upload_data    (upload_data),
        .upload_valid   (upload_valid),
        .upload_ready   (upload_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  flags;
        logic [15:0] len;
        logic [31:0] decim;
        int          ready_pct;
        int          exp_n;
        int          exp_total;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] sa_q[$];
    logic [13:0] sb_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  ref_q[$];
    logic [7:0]  want_q[$];
    bit          stall_ok;
    bit          src_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic int model_n(input logic [15:0] ln);
        return (int'(ln) > DEPTH) ? DEPTH : int'(ln);
    endfunction

    task automatic fill_random(input int cnt);
        sa_q.delete();
        sb_q.delete();
        for (int i = 0; i < cnt; i++) begin
            sa_q.push_back(14'($urandom));
            sb_q.push_back(14'($urandom));
        end
    endtask

    task automatic prep(input logic [15:0] ln, input logic [31:0] dc);
        fill_random(model_n(ln) * (int'(dc) + 1) + 8);
    endtask

    // Expected packet: header, then every (decim+1)-th strobe's sample as (s + 8192) LE.
    task automatic build_expected(input logic [7:0] fl, input logic [15:0] ln,
                                  input logic [31:0] dc);
        int                 n, idx, raw;
        logic signed [13:0] s;
        n = model_n(ln);
        exp_q.delete();
        exp_q.push_back(fl);
        exp_q.push_back(8'(n / 256));
        exp_q.push_back(8'(n % 256));
        exp_q.push_back(dc[31:24]);
        exp_q.push_back(dc[23:16]);
        exp_q.push_back(dc[15:8]);
        exp_q.push_back(dc[7:0]);
        for (int k = 0; k < n; k++) begin
            idx = k * (int'(dc) + 1);
            s   = fl[3] ? sb_q[idx] : sa_q[idx];
            raw = (int'(s) + 8192) % 16384;
            exp_q.push_back(8'(raw % 256));
            exp_q.push_back(8'(raw / 256));
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] fl, input logic [15:0] ln,
                            input logic [31:0] dc);
        logic [7:0] b [7];
        b = '{fl, ln[15:8], ln[7:0], dc[31:24], dc[23:16], dc[15:8], dc[7:0]};
        cmd_type  = op;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cmd_data       = b[i];
            cmd_data_index = 16'(i);
            cmd_data_valid = 1'b1;
            tick();
        end
        cmd_data       = 8'hAA;
        cmd_data_index = 16'd7;
        tick();
        cmd_data_valid = 1'b0;
        cmd_done       = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
    endtask

    task automatic feed(input logic [15:0] ln, input logic [31:0] dc, input bit inject);
        int need;
        need = (model_n(ln) - 1) * (int'(dc) + 1) + 1 + 3;
        for (int i = 0; i < need; i++) begin
            if ($urandom_range(3) == 0) tick();
            sample_a     = sa_q[i];
            sample_b     = sb_q[i];
            sample_valid = 1'b1;
            if (inject && (i == 1 || i == 2)) begin
                cmd_start      = 1'b1;
                cmd_type       = (i == 1) ? 8'hFC : 8'hFD;
                cmd_data_valid = 1'b1;
                cmd_data_index = 16'd0;
                cmd_data       = 8'hFF;
                cmd_done       = (i == 2);
            end
            @(negedge clk);
            if (inject && (i == 1 || i == 2)) begin
                check($sformatf("inject_cmd_ready_%0d", i), 64'(cmd_ready), 64'd0);
            end
            tick();
            sample_valid   = 1'b0;
            cmd_start      = 1'b0;
            cmd_data_valid = 1'b0;
            cmd_done       = 1'b0;
        end
    endtask

    task automatic receive(input int pct, input int max_bytes, input int budget);
        bit         stalled;
        logic [7:0] held;
        stalled  = 1'b0;
        held     = '0;
        stall_ok = 1'b1;
        src_ok   = 1'b1;
        got_q.delete();
        for (int cyc = 0; cyc < budget && got_q.size() < max_bytes; cyc++) begin
            upload_ready = ($urandom_range(99) < pct);
            @(negedge clk);
            if (stalled && (!upload_valid || upload_data != held)) stall_ok = 1'b0;
            if (upload_valid && (!upload_req || upload_source != 8'hFD)) src_ok = 1'b0;
            stalled = upload_valid && !upload_ready;
            held    = upload_data;
            if (upload_valid && upload_ready) got_q.push_back(upload_data);
            tick();
        end
        upload_ready = 1'b0;
    endtask

    task automatic compare_stream(input string name, input logic [7:0] want[$]);
        int bad;
        check({name, "_len"}, 64'(got_q.size()), 64'(want.size()));
        bad = -1;
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            if (bad < 0 && got_q[i] !== want[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s_bytes: byte %0d got %0h, want %0h", name, bad, got_q[bad], want[bad]);
        end
    endtask

    task automatic run_case(input string name, input logic [7:0] fl, input logic [15:0] ln,
                            input logic [31:0] dc, input int pct, input bit inject);
        build_expected(fl, ln, dc);
        send_cmd(8'hFD, fl, ln, dc);
        feed(ln, dc, inject);
        receive(pct, exp_q.size(), 20000);
        check({name, "_req_drop"}, 64'({upload_req, busy}), 64'd0);
        compare_stream(name, exp_q);
        check({name, "_stable"}, 64'(stall_ok), 64'd1);
        check({name, "_source"}, 64'(src_ok), 64'd1);
    endtask

    vec_t vecs [6];

    initial begin
        logic [7:0] t1 [15];
        logic [7:0] t2 [13];
        bit         saw_req;

        vecs[0] = '{flags: 8'h00, len: 16'd300, decim: 32'd0, ready_pct: 100,
                    exp_n: 256, exp_total: 519};
        vecs[1] = '{flags: 8'h08, len: 16'd17, decim: 32'd1, ready_pct: 30,
                    exp_n: 17, exp_total: 41};
        vecs[2] = '{flags: 8'h00, len: 16'd256, decim: 32'd0, ready_pct: 30,
                    exp_n: 256, exp_total: 519};
        vecs[3] = '{flags: 8'h08, len: 16'd1, decim: 32'd3, ready_pct: 30,
                    exp_n: 1, exp_total: 9};
        vecs[4] = '{flags: 8'hF7, len: 16'd9, decim: 32'd2, ready_pct: 60,
                    exp_n: 9, exp_total: 25};
        vecs[5] = '{flags: 8'h08, len: 16'd255, decim: 32'd0, ready_pct: 100,
                    exp_n: 255, exp_total: 517};

        repeat (3) tick();
        check("reset_outputs",
              64'({cmd_ready, busy, upload_req, upload_valid, upload_source, upload_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
        rst = 1'b0;
        tick();

        // Foreign opcode in idle is ignored.
        send_cmd(8'hFC, 8'h00, 16'd4, 32'd0);
        check("fc_idle_ignored", 64'(busy), 64'd0);

        // Known samples on channel A, every strobe.
        fill_random(16);
        sa_q[0] = 14'h2000;
        sa_q[1] = 14'h3FFF;
        sa_q[2] = 14'h0000;
        sa_q[3] = 14'h1FFF;
        run_case("t1", 8'h00, 16'd4, 32'd0, 100, 1'b0);
        t1 = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'hFF, 8'h1F, 8'h00, 8'h20, 8'hFF, 8'h3F};
        want_q.delete();
        foreach (t1[i]) want_q.push_back(t1[i]);
        compare_stream("t1_const", want_q);

        // Channel B ramp with decimation 2.
        fill_random(20);
        for (int i = 0; i < 12; i++) sb_q[i] = 14'(i);
        run_case("t2", 8'h08, 16'd3, 32'd2, 100, 1'b0);
        t2 = '{8'h08, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02,
               8'h00, 8'h20, 8'h03, 8'h20, 8'h06, 8'h20};
        want_q.delete();
        foreach (t2[i]) want_q.push_back(t2[i]);
        compare_stream("t2_const", want_q);

        foreach (vecs[v]) begin
            prep(vecs[v].len, vecs[v].decim);
            run_case($sformatf("vec%0d", v), vecs[v].flags, vecs[v].len, vecs[v].decim,
                     vecs[v].ready_pct, 1'b0);
            check($sformatf("vec%0d_total", v), 64'(got_q.size()), 64'(vecs[v].exp_total));
            if (got_q.size() >= 3) begin
                check($sformatf("vec%0d_hdr_n", v), 64'({got_q[1], got_q[2]}),
                      64'(vecs[v].exp_n));
            end
        end

        // Same capture data, ready always vs random back-pressure.
        prep(16'd40, 32'd1);
        run_case("rdy100", 8'h08, 16'd40, 32'd1, 100, 1'b0);
        ref_q = got_q;
        run_case("rdy30", 8'h08, 16'd40, 32'd1, 30, 1'b0);
        compare_stream("rdy_equiv", ref_q);

        // len == 0: no upload at all.
        send_cmd(8'hFD, 8'h00, 16'd0, 32'd5);
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'b1;
            @(negedge clk);
            if (upload_req) saw_req = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
        check("len0_no_req", 64'(saw_req), 64'd0);
        check("len0_idle", 64'({busy, cmd_ready}), 64'(2'b01));

        // Commands during capture are ignored.
        prep(16'd8, 32'd1);
        run_case("inject", 8'h00, 16'd8, 32'd1, 100, 1'b1);

        // Reset while the high byte of sample 10 is presented.
        prep(16'd20, 32'd0);
        build_expected(8'h00, 16'd20, 32'd0);
        send_cmd(8'hFD, 8'h00, 16'd20, 32'd0);
        feed(16'd20, 32'd0, 1'b0);
        receive(100, 28, 2000);
        @(negedge clk);
        check("rst_pre_byte", 64'({upload_valid, upload_data}), 64'({1'b1, exp_q[28]}));
        rst = 1'b1;
        tick();
        check("rst_mid_outputs",
              64'({cmd_ready, busy, upload_req, upload_valid, upload_source, upload_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00}));
        rst = 1'b0;
        tick();
        prep(16'd12, 32'd1);
        run_case("after_rst", 8'h08, 16'd12, 32'd1, 50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
